gba_cmd_decoder: RTL

- Parametrised UART command front-end for the GBA cartridge dumper. Successor to the fixed single-byte size decoder.
- Accepts single-byte legacy commands plus a multi-byte range-dump command (start address + length), abort and status queries.
- Sits between uart_recv and the pak reader. Emits a one-byte ASCII response per command on a valid/ready port that the top level muxes onto uart_send.

---
 rtl/gba_cmd_decoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gba_cmd_decoder.sv
// UART command front-end for the GBA cartridge dumper: legacy size bytes,
// range-dump frames, abort and status, one ASCII response per command.
module gba_cmd_decoder #(
  parameter int ADDR_W         = 24,
  parameter int LEN_W          = 25,
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic              pin_clk,
  input  logic              pin_resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              dump_busy,
  output logic              dump_start,
  output logic              dump_abort,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [LEN_W-1:0]  dump_len,
  output logic [7:0]        resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARGS, RESP} state_t;

  state_t          state;
  logic [39:0]     sh;
  logic [2:0]      cnt;
  logic [TW-1:0]   tmo;

  logic [47:0]     full;
  logic [ADDR_W-1:0] arg_addr;
  logic [LEN_W-1:0]  arg_len;
  logic [LEN_W:0]    arg_end;
  logic [LEN_W:0]    limit;
  logic              arg_bad;

  logic              leg_hit;
  logic [LEN_W-1:0]  leg_len;

  // Sixth byte is combined with the five already shifted in.
  assign full     = {sh, rx_data};
  assign arg_addr = ADDR_W'(full[47:24]);
  assign arg_len  = LEN_W'(full[23:0]);
  assign arg_end  = {1'b0, arg_len} + (LEN_W+1)'(arg_addr);
  assign limit    = (LEN_W+1)'(1) << ADDR_W;
  assign arg_bad  = (arg_len == '0) || (arg_end > limit);

  always_comb begin
    leg_hit = 1'b1;
    leg_len = '0;
    case (rx_data)
      8'h61:   leg_len = LEN_W'(32'h0020_0000);
      8'h62:   leg_len = LEN_W'(32'h0040_0000);
      8'h63:   leg_len = LEN_W'(32'h0080_0000);
      8'h64:   leg_len = LEN_W'(32'h0100_0000);
      8'h68:   leg_len = LEN_W'(32'h0000_0060);
      default: leg_hit = 1'b0;
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_resetn) begin
    if (!pin_resetn) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      tmo        <= '0;
      dump_start <= 1'b0;
      dump_abort <= 1'b0;
      dump_addr  <= '0;
      dump_len   <= '0;
      resp_data  <= 8'h00;
      resp_valid <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      dump_start <= 1'b0;
      dump_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            resp_valid <= 1'b1;
            state      <= RESP;
            unique case (1'b1)
              leg_hit && dump_busy: resp_data <= "E";
              leg_hit && !dump_busy: begin
                dump_start <= 1'b1;
                dump_addr  <= '0;
                dump_len   <= leg_len;
                resp_data  <= "K";
              end
              rx_data == 8'h72: begin
                resp_valid <= 1'b0;
                state      <= ARGS;
                sh         <= '0;
                cnt        <= '0;
                tmo        <= '0;
              end
              rx_data == 8'h78: begin
                dump_abort <= dump_busy;
                resp_data  <= dump_busy ? "K" : "E";
              end
              rx_data == 8'h3f: resp_data <= dump_busy ? "B" : "I";
              default:          resp_data <= "E";
            endcase
          end
        end
        ARGS: begin
          if (rx_valid) begin
            tmo <= '0;
            if (cnt == 3'd5) begin
              resp_valid <= 1'b1;
              state      <= RESP;
              if (arg_bad || dump_busy) begin
                resp_data <= "E";
              end else begin
                dump_start <= 1'b1;
                dump_addr  <= arg_addr;
                dump_len   <= arg_len;
                resp_data  <= "K";
              end
            end else begin
              sh  <= {sh[31:0], rx_data};
              cnt <= cnt + 3'd1;
            end
          end else if (tmo == TMO_LAST) begin
            resp_valid <= 1'b1;
            resp_data  <= "T";
            state      <= RESP;
            sh         <= '0;
            cnt        <= '0;
            tmo        <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RESP: begin
          if (rx_valid && drop_count != 8'hff)
            drop_count <= drop_count + 8'd1;
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
